atm_session_ctrl: RTL and testbench
===================================

Name: atm_session_ctrl

Overview:
- Session sequencer for the crypto ATM. Consumes keypad ASCII strobes and walks the session through its states: idle, account entry, PIN entry, menu, operation, success and error.
- Owns the account and PIN digit buffers, the table compare, PIN-retry lockout and the inactivity timeout.
- Publishes the 5-bit state code and 4-bit status codes used by the display and operation blocks.
- Downstream operation blocks report completion back through op_done / op_err.

Parameters:
- TIMEOUT_CYCLES, 1000, inactivity limit in clk cycles for any non-IDLE state.
- MAX_PIN_TRIES, 3, consecutive wrong PINs before the account is locked.
- ACCT1 / ACCT2 / ACCT3, 16'h7777 / 16'h1111 / 16'h3333, account table; index 0..2.
- PIN1 / PIN2 / PIN3, 16'h7777 / 16'h1111 / 16'h3333, PIN for the same index.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle strobe; ascii_code is valid in this cycle.
- ascii_code  in  8  key pressed.
- op_done  in  1  one-cycle pulse: current operation finished OK.
- op_err  in  1  one-cycle pulse: current operation failed.
- state  out  5  current state code.
- status_code  out  4  last status code.
- status_valid  out  1  one-cycle pulse when status_code is updated.
- acct  out  16  account digit buffer, BCD nibbles, newest digit in [3:0].
- pswd  out  16  PIN digit buffer, same format.
- acct_idx  out  2  matched account 0..2; 3 = none.
- digit_count  out  3  digits held in the active buffer, 0..4.
- locked  out  3  per-account lock bits.

Behaviour:
- Clocking: all outputs are registered. Responses appear in the cycle after key_valid / op_* is sampled.
- Reset: state=IDLE, status_code=0, status_valid=0, acct=0, pswd=0, acct_idx=3, digit_count=0, locked=0, tries=0, timer=0.
- State codes: IDLE 00001, ACC_NUM 00010, PIN_INPUT 00011, MENU 00100, SHOW_BALANCES 00101, CONVERT_CURRENCY 00110, WITHDRAW 01001, TRANSFER 01011, ERROR 01110, SUCCESS 01111.
- Status codes: ACC_FOUND 1, ACC_NOT_FOUND 2, PIN_CORRECT 3, PIN_INCORRECT 4, EXIT 7, INPUT_COMPLETE 8.
- Digit entry (ACC_NUM, PIN_INPUT):
  - Keys 0x30..0x39 with digit_count<4: buf <= {buf[11:0], ascii[3:0]}, digit_count+1.
  - A fifth digit is ignored.
  - Backspace 0x08: buf <= buf>>4, digit_count-1; ignored when digit_count=0.
  - Enter 0x0D with digit_count<4 is ignored: no pulse, no state change.
- IDLE:
  - Enter goes to ACC_NUM; acct, pswd and digit_count are cleared. No status pulse.
  - All other keys are ignored. Timer is held at 0.
- ACC_NUM, Enter with 4 digits:
  - acct matches table entry i and locked[i]=0: acct_idx=i, pulse ACC_FOUND, go to PIN_INPUT, digit_count=0, tries=0.
  - No match, or matched entry is locked: acct_idx=3, pulse ACC_NOT_FOUND, go to ERROR.
- PIN_INPUT, Enter with 4 digits: compare only against PIN[acct_idx].
  - Match: pulse PIN_CORRECT, tries=0, go to MENU.
  - Mismatch: pulse PIN_INCORRECT, tries+1, pswd=0, digit_count=0.
  - If tries+1 == MAX_PIN_TRIES: set locked[acct_idx] and go to ERROR; otherwise stay in PIN_INPUT.
- MENU:
  - 'b' 0x62 goes to SHOW_BALANCES, 'c' 0x63 to CONVERT_CURRENCY, 'w' 0x77 to WITHDRAW, 't' 0x74 to TRANSFER; each pulses INPUT_COMPLETE.
  - Other keys are ignored.
- Operation states:
  - op_done goes to SUCCESS; op_err goes to ERROR. If both arrive together, op_err wins.
  - Keys other than 'q' are ignored.
- SUCCESS: unconditionally returns to MENU after 1 cycle.
- ERROR: any key except 'q' returns to IDLE with all buffers cleared and acct_idx=3. 'q' exits as below.
- Exit: 'q' 0x71 in any non-IDLE state pulses EXIT and goes to IDLE. Clears acct, pswd, digit_count, tries; acct_idx=3.
- Timeout:
  - The timer counts each cycle in non-IDLE states and clears on key_valid or op_*.
  - At TIMEOUT_CYCLES-1 it performs the same actions as exit, including the EXIT pulse.
- Priority within one cycle: 'q' > timeout > op_err > op_done > state-specific key handling.
- Lock persistence: locked bits persist across sessions and clear only on reset.
- Mid-session reset: asynchronous; all state returns to reset values immediately.

Test Plan:
- Happy path: Enter, keys 7,7,7,7, Enter. Expect ACC_FOUND pulse, acct=16'h7777, acct_idx=0, state=PIN_INPUT. Then 7,7,7,7, Enter. Expect PIN_CORRECT pulse, state=MENU. Then 'w'. Expect INPUT_COMPLETE, state=WITHDRAW. Then op_done. Expect SUCCESS for 1 cycle, then MENU.
- Edit rules: in ACC_NUM send 1,2,0x08,1,1,1,9 then Enter. Expect acct=16'h1111 (the 9 is dropped). Enter with only 3 digits produces no pulse and no state change.
- Lockout: account 3333, then wrong PIN 1111 three times. Expect PIN_INCORRECT ×3, locked=3'b100, state=ERROR. A new session with 3333 then gives ACC_NOT_FOUND.
- Cross-PIN: account 1111 with PIN 7777. Expect PIN_INCORRECT: another account's PIN must not be accepted.
- Timeout: TIMEOUT_CYCLES=20, sit in MENU idle. Expect EXIT pulse and state=IDLE 20 cycles after the last key. A key at cycle 19 restarts the count.
- Priority/reset: in TRANSFER, op_done + op_err together gives ERROR; 'q' + op_done together gives EXIT/IDLE. Deassert-then-assert rst_n mid PIN_INPUT: expect every output at its reset value.

Source files
------------

// File: rtl/atm_session_ctrl.sv
// Session sequencer for the crypto ATM: keypad-driven state walk, account/PIN
// buffers, table compare, PIN-retry lockout and inactivity timeout.
`timescale 1ns/1ps
module atm_session_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_PIN_TRIES  = 3,
  parameter logic [15:0] ACCT1          = 16'h7777,
  parameter logic [15:0] ACCT2          = 16'h1111,
  parameter logic [15:0] ACCT3          = 16'h3333,
  parameter logic [15:0] PIN1           = 16'h7777,
  parameter logic [15:0] PIN2           = 16'h1111,
  parameter logic [15:0] PIN3           = 16'h3333
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [7:0]  ascii_code,
  input  logic        op_done,
  input  logic        op_err,
  output logic [4:0]  state,
  output logic [3:0]  status_code,
  output logic        status_valid,
  output logic [15:0] acct,
  output logic [15:0] pswd,
  output logic [1:0]  acct_idx,
  output logic [2:0]  digit_count,
  output logic [2:0]  locked
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TRIES_W = $clog2(MAX_PIN_TRIES + 1);

  localparam logic [7:0] KEY_ENTER = 8'h0D;
  localparam logic [7:0] KEY_BKSP  = 8'h08;
  localparam logic [7:0] KEY_QUIT  = 8'h71;
  localparam logic [7:0] KEY_BAL   = 8'h62;
  localparam logic [7:0] KEY_CONV  = 8'h63;
  localparam logic [7:0] KEY_WDRAW = 8'h77;
  localparam logic [7:0] KEY_XFER  = 8'h74;

  localparam logic [3:0] ST_ACC_FOUND      = 4'd1;
  localparam logic [3:0] ST_ACC_NOT_FOUND  = 4'd2;
  localparam logic [3:0] ST_PIN_CORRECT    = 4'd3;
  localparam logic [3:0] ST_PIN_INCORRECT  = 4'd4;
  localparam logic [3:0] ST_EXIT           = 4'd7;
  localparam logic [3:0] ST_INPUT_COMPLETE = 4'd8;

  localparam logic [1:0] IDX_NONE = 2'd3;

  typedef enum logic [4:0] {
    S_IDLE             = 5'b00001,
    S_ACC_NUM          = 5'b00010,
    S_PIN_INPUT        = 5'b00011,
    S_MENU             = 5'b00100,
    S_SHOW_BALANCES    = 5'b00101,
    S_CONVERT_CURRENCY = 5'b00110,
    S_WITHDRAW         = 5'b01001,
    S_TRANSFER         = 5'b01011,
    S_ERROR            = 5'b01110,
    S_SUCCESS          = 5'b01111
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         status_code_q, status_code_d;
  logic               status_valid_q, status_valid_d;
  logic [15:0]        acct_q, acct_d;
  logic [15:0]        pswd_q, pswd_d;
  logic [1:0]         acct_idx_q, acct_idx_d;
  logic [2:0]         digit_count_q, digit_count_d;
  logic [2:0]         locked_q, locked_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  logic is_enter, is_quit, is_bksp, is_digit, activity, timeout;
  assign is_enter = key_valid && (ascii_code == KEY_ENTER);
  assign is_quit  = key_valid && (ascii_code == KEY_QUIT);
  assign is_bksp  = key_valid && (ascii_code == KEY_BKSP);
  assign is_digit = key_valid && (ascii_code >= 8'h30) && (ascii_code <= 8'h39);
  assign activity = key_valid | op_done | op_err;
  assign timeout  = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

  // Shift-register edit of whichever digit buffer is active
  logic [15:0] edit_src, edit_buf;
  logic [2:0]  edit_cnt;
  always_comb begin
    edit_src = (state_q == S_PIN_INPUT) ? pswd_q : acct_q;
    edit_buf = edit_src;
    edit_cnt = digit_count_q;
    if (is_digit && (digit_count_q < 3'd4)) begin
      edit_buf = {edit_src[11:0], ascii_code[3:0]};
      edit_cnt = digit_count_q + 3'd1;
    end else if (is_bksp && (digit_count_q != 3'd0)) begin
      edit_buf = edit_src >> 4;
      edit_cnt = digit_count_q - 3'd1;
    end
  end

  // Account table lookup and PIN reference for the matched account
  logic        match_valid, match_locked, pin_ok;
  logic [1:0]  match_idx;
  logic [15:0] pin_ref;
  always_comb begin
    match_valid  = 1'b1;
    match_idx    = IDX_NONE;
    match_locked = 1'b0;
    if (acct_q == ACCT1) begin
      match_idx    = 2'd0;
      match_locked = locked_q[0];
    end else if (acct_q == ACCT2) begin
      match_idx    = 2'd1;
      match_locked = locked_q[1];
    end else if (acct_q == ACCT3) begin
      match_idx    = 2'd2;
      match_locked = locked_q[2];
    end else begin
      match_valid = 1'b0;
    end
    case (acct_idx_q)
      2'd0:    pin_ref = PIN1;
      2'd1:    pin_ref = PIN2;
      default: pin_ref = PIN3;
    endcase
    pin_ok = (acct_idx_q != IDX_NONE) && (pswd_q == pin_ref);
  end

  logic [TRIES_W-1:0] tries_inc;
  assign tries_inc = tries_q + TRIES_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    status_code_d  = status_code_q;
    status_valid_d = 1'b0;
    acct_d         = acct_q;
    pswd_d         = pswd_q;
    acct_idx_d     = acct_idx_q;
    digit_count_d  = digit_count_q;
    locked_d       = locked_q;
    tries_d        = tries_q;
    timer_d        = timer_q;

    if (state_q == S_IDLE) begin
      timer_d = '0;
      if (is_enter) begin
        state_d       = S_ACC_NUM;
        acct_d        = '0;
        pswd_d        = '0;
        digit_count_d = '0;
      end
    end else if (is_quit || timeout) begin
      state_d        = S_IDLE;
      status_code_d  = ST_EXIT;
      status_valid_d = 1'b1;
      acct_d         = '0;
      pswd_d         = '0;
      digit_count_d  = '0;
      tries_d        = '0;
      acct_idx_d     = IDX_NONE;
      timer_d        = '0;
    end else begin
      timer_d = activity ? '0 : timer_q + TIMER_W'(1);
      case (state_q)
        S_ACC_NUM: begin
          acct_d        = edit_buf;
          digit_count_d = edit_cnt;
          if (is_enter && (digit_count_q == 3'd4)) begin
            status_valid_d = 1'b1;
            if (match_valid && !match_locked) begin
              acct_idx_d    = match_idx;
              status_code_d = ST_ACC_FOUND;
              state_d       = S_PIN_INPUT;
              digit_count_d = '0;
              tries_d       = '0;
            end else begin
              acct_idx_d    = IDX_NONE;
              status_code_d = ST_ACC_NOT_FOUND;
              state_d       = S_ERROR;
            end
          end
        end
        S_PIN_INPUT: begin
          pswd_d        = edit_buf;
          digit_count_d = edit_cnt;
          if (is_enter && (digit_count_q == 3'd4)) begin
            status_valid_d = 1'b1;
            if (pin_ok) begin
              status_code_d = ST_PIN_CORRECT;
              tries_d       = '0;
              state_d       = S_MENU;
            end else begin
              status_code_d = ST_PIN_INCORRECT;
              tries_d       = tries_inc;
              pswd_d        = '0;
              digit_count_d = '0;
              if (tries_inc == TRIES_W'(MAX_PIN_TRIES)) begin
                locked_d = locked_q | (3'b001 << acct_idx_q);
                state_d  = S_ERROR;
              end
            end
          end
        end
        S_MENU: begin
          if (key_valid) begin
            status_code_d = ST_INPUT_COMPLETE;
            case (ascii_code)
              KEY_BAL:   begin state_d = S_SHOW_BALANCES;    status_valid_d = 1'b1; end
              KEY_CONV:  begin state_d = S_CONVERT_CURRENCY; status_valid_d = 1'b1; end
              KEY_WDRAW: begin state_d = S_WITHDRAW;         status_valid_d = 1'b1; end
              KEY_XFER:  begin state_d = S_TRANSFER;         status_valid_d = 1'b1; end
              default:   status_code_d = status_code_q;
            endcase
          end
        end
        S_SHOW_BALANCES, S_CONVERT_CURRENCY, S_WITHDRAW, S_TRANSFER: begin
          if (op_err)       state_d = S_ERROR;
          else if (op_done) state_d = S_SUCCESS;
        end
        S_SUCCESS: state_d = S_MENU;
        S_ERROR: begin
          if (key_valid) begin
            state_d       = S_IDLE;
            acct_d        = '0;
            pswd_d        = '0;
            digit_count_d = '0;
            tries_d       = '0;
            acct_idx_d    = IDX_NONE;
            timer_d       = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      status_code_q  <= '0;
      status_valid_q <= 1'b0;
      acct_q         <= '0;
      pswd_q         <= '0;
      acct_idx_q     <= IDX_NONE;
      digit_count_q  <= '0;
      locked_q       <= '0;
      tries_q        <= '0;
      timer_q        <= '0;
    end else begin
      state_q        <= state_d;
      status_code_q  <= status_code_d;
      status_valid_q <= status_valid_d;
      acct_q         <= acct_d;
      pswd_q         <= pswd_d;
      acct_idx_q     <= acct_idx_d;
      digit_count_q  <= digit_count_d;
      locked_q       <= locked_d;
      tries_q        <= tries_d;
      timer_q        <= timer_d;
    end
  end

  assign state        = state_q;
  assign status_code  = status_code_q;
  assign status_valid = status_valid_q;
  assign acct         = acct_q;
  assign pswd         = pswd_q;
  assign acct_idx     = acct_idx_q;
  assign digit_count  = digit_count_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl: session flows, edit rules, lockout,
// timeout, priority and asynchronous reset.
`timescale 1ns/1ps
module tb_atm_session_ctrl;

  localparam logic [4:0] S_IDLE = 5'b00001, S_ACC = 5'b00010, S_PIN = 5'b00011,
                         S_MENU = 5'b00100, S_WD = 5'b01001, S_XFER = 5'b01011,
                         S_ERR = 5'b01110, S_SUCC = 5'b01111;
  localparam logic [7:0] ENTER = 8'h0D, BKSP = 8'h08, QUIT = 8'h71;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [7:0]  ascii_code;
  logic        op_done, op_err;
  logic [4:0]  state;
  logic [3:0]  status_code;
  logic        status_valid;
  logic [15:0] acct, pswd;
  logic [1:0]  acct_idx;
  logic [2:0]  digit_count;
  logic [2:0]  locked;

  int n_cmp = 0;
  int n_err = 0;

  atm_session_ctrl #(.TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .ascii_code(ascii_code),
    .op_done(op_done), .op_err(op_err), .state(state), .status_code(status_code),
    .status_valid(status_valid), .acct(acct), .pswd(pswd), .acct_idx(acct_idx),
    .digit_count(digit_count), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_key(input logic [7:0] c);
    @(negedge clk);
    key_valid  = 1'b1;
    ascii_code = c;
    @(negedge clk);
    key_valid  = 1'b0;
    ascii_code = 8'h00;
  endtask

  task automatic send_digits(input logic [15:0] v);
    for (int i = 3; i >= 0; i--) send_key(8'h30 | {4'h0, v[i*4 +: 4]});
  endtask

  task automatic pulse_op(input logic d, input logic e, input logic q);
    @(negedge clk);
    op_done    = d;
    op_err     = e;
    key_valid  = q;
    ascii_code = q ? QUIT : 8'h00;
    @(negedge clk);
    op_done    = 1'b0;
    op_err     = 1'b0;
    key_valid  = 1'b0;
    ascii_code = 8'h00;
  endtask

  task automatic to_menu(input logic [15:0] a, input logic [15:0] p);
    send_key(ENTER);
    send_digits(a);
    send_key(ENTER);
    send_digits(p);
    send_key(ENTER);
  endtask

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; ascii_code = 8'h00; op_done = 1'b0; op_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_status", 32'(status_code), 32'h0);
    chk("rst_valid", 32'(status_valid), 32'h0);
    chk("rst_acct", 32'(acct), 32'h0);
    chk("rst_idx", 32'(acct_idx), 32'h3);
    chk("rst_locked", 32'(locked), 32'h0);
    rst_n = 1'b1;

    // Happy path
    send_key(ENTER);
    chk("hp_accnum", 32'(state), 32'(S_ACC));
    chk("hp_enter_nopulse", 32'(status_valid), 32'h0);
    send_digits(16'h7777);
    chk("hp_acct", 32'(acct), 32'h7777);
    chk("hp_cnt4", 32'(digit_count), 32'h4);
    send_key(ENTER);
    chk("hp_found_v", 32'(status_valid), 32'h1);
    chk("hp_found_c", 32'(status_code), 32'h1);
    chk("hp_idx", 32'(acct_idx), 32'h0);
    chk("hp_pin_state", 32'(state), 32'(S_PIN));
    chk("hp_cnt0", 32'(digit_count), 32'h0);
    send_digits(16'h7777);
    send_key(ENTER);
    chk("hp_pin_ok_c", 32'(status_code), 32'h3);
    chk("hp_menu", 32'(state), 32'(S_MENU));
    send_key(8'h77);
    chk("hp_w_c", 32'(status_code), 32'h8);
    chk("hp_w_v", 32'(status_valid), 32'h1);
    chk("hp_withdraw", 32'(state), 32'(S_WD));
    pulse_op(1'b1, 1'b0, 1'b0);
    chk("hp_success", 32'(state), 32'(S_SUCC));
    @(negedge clk);
    chk("hp_back_menu", 32'(state), 32'(S_MENU));
    send_key(QUIT);
    chk("hp_exit_c", 32'(status_code), 32'h7);
    chk("hp_exit_v", 32'(status_valid), 32'h1);
    chk("hp_exit_state", 32'(state), 32'(S_IDLE));
    chk("hp_exit_idx", 32'(acct_idx), 32'h3);
    chk("hp_exit_acct", 32'(acct), 32'h0);

    // Edit rules
    send_key(ENTER);
    send_key("1");
    send_key("2");
    chk("ed_12", 32'(acct), 32'h0012);
    send_key(BKSP);
    chk("ed_bksp", 32'(acct), 32'h0001);
    chk("ed_bksp_cnt", 32'(digit_count), 32'h1);
    send_key("1");
    send_key("1");
    send_key("1");
    send_key("9");
    chk("ed_fifth_drop", 32'(acct), 32'h1111);
    chk("ed_cnt_sat", 32'(digit_count), 32'h4);
    send_key(BKSP);
    send_key(ENTER);
    chk("ed_short_nopulse", 32'(status_valid), 32'h0);
    chk("ed_short_state", 32'(state), 32'(S_ACC));
    chk("ed_short_cnt", 32'(digit_count), 32'h3);
    send_key("1");
    send_key(ENTER);
    chk("ed_found_c", 32'(status_code), 32'h1);
    chk("ed_idx1", 32'(acct_idx), 32'h1);

    // Cross-PIN: account 1111 must reject PIN 7777
    send_digits(16'h7777);
    send_key(ENTER);
    chk("xp_bad_c", 32'(status_code), 32'h4);
    chk("xp_bad_v", 32'(status_valid), 32'h1);
    chk("xp_stay", 32'(state), 32'(S_PIN));
    chk("xp_pswd_clr", 32'(pswd), 32'h0);
    send_key(QUIT);
    chk("xp_idle", 32'(state), 32'(S_IDLE));

    // Lockout of account 3333
    send_key(ENTER);
    send_digits(16'h3333);
    send_key(ENTER);
    chk("lk_idx2", 32'(acct_idx), 32'h2);
    for (int t = 0; t < 3; t++) begin
      send_digits(16'h1111);
      send_key(ENTER);
      chk("lk_bad_c", 32'(status_code), 32'h4);
      chk("lk_bad_v", 32'(status_valid), 32'h1);
      chk("lk_state", 32'(state), (t < 2) ? 32'(S_PIN) : 32'(S_ERR));
    end
    chk("lk_locked", 32'(locked), 32'h4);
    send_key(8'h61);
    chk("lk_err_idle", 32'(state), 32'(S_IDLE));
    chk("lk_err_idx", 32'(acct_idx), 32'h3);
    send_key(ENTER);
    send_digits(16'h3333);
    send_key(ENTER);
    chk("lk_notfound_c", 32'(status_code), 32'h2);
    chk("lk_notfound_st", 32'(state), 32'(S_ERR));
    chk("lk_notfound_idx", 32'(acct_idx), 32'h3);
    send_key(QUIT);
    chk("lk_err_quit_c", 32'(status_code), 32'h7);
    chk("lk_err_quit_st", 32'(state), 32'(S_IDLE));
    chk("lk_persist", 32'(locked), 32'h4);

    // Priority: op_err beats op_done; 'q' beats op_done
    to_menu(16'h1111, 16'h1111);
    send_key(8'h74);
    chk("pr_xfer", 32'(state), 32'(S_XFER));
    pulse_op(1'b1, 1'b1, 1'b0);
    chk("pr_err_wins", 32'(state), 32'(S_ERR));
    send_key(8'h61);
    to_menu(16'h1111, 16'h1111);
    send_key(8'h74);
    pulse_op(1'b1, 1'b0, 1'b1);
    chk("pr_q_state", 32'(state), 32'(S_IDLE));
    chk("pr_q_c", 32'(status_code), 32'h7);
    chk("pr_q_v", 32'(status_valid), 32'h1);

    // Timeout from MENU, 20 cycles after last key
    to_menu(16'h7777, 16'h7777);
    repeat (19) @(negedge clk);
    chk("to_before", 32'(state), 32'(S_MENU));
    @(negedge clk);
    chk("to_fire_st", 32'(state), 32'(S_IDLE));
    chk("to_fire_v", 32'(status_valid), 32'h1);
    chk("to_fire_c", 32'(status_code), 32'h7);

    // Key at cycle 19 restarts the count
    to_menu(16'h7777, 16'h7777);
    repeat (17) @(negedge clk);
    send_key(8'h7A);
    chk("to_restart_st", 32'(state), 32'(S_MENU));
    repeat (19) @(negedge clk);
    chk("to_restart_hold", 32'(state), 32'(S_MENU));
    @(negedge clk);
    chk("to_restart_fire", 32'(state), 32'(S_IDLE));
    chk("to_restart_v", 32'(status_valid), 32'h1);

    // Asynchronous reset mid PIN entry
    send_key(ENTER);
    send_digits(16'h7777);
    send_key(ENTER);
    send_key("1");
    send_key("2");
    chk("ar_pre_pswd", 32'(pswd), 32'h0012);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state", 32'(state), 32'(S_IDLE));
    chk("ar_status", 32'(status_code), 32'h0);
    chk("ar_valid", 32'(status_valid), 32'h0);
    chk("ar_acct", 32'(acct), 32'h0);
    chk("ar_pswd", 32'(pswd), 32'h0);
    chk("ar_idx", 32'(acct_idx), 32'h3);
    chk("ar_cnt", 32'(digit_count), 32'h0);
    chk("ar_locked", 32'(locked), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
